// File: rtl/mac_sum_argmax.sv
// N offset-subtracting MAC lanes reduced by a registered ternary adder tree,
// plus a sequential argmax over 10 signed elements.
module mac_sum_argmax #(
   parameter int N         = 27,
   parameter int MAC_WIDTH = 24,
   parameter int SUM_WIDTH = 24,
   parameter int ARG_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          en,
   input  logic                          acc,
   input  logic [N*8-1:0]                a,
   input  logic [N*8-1:0]                b,
   input  logic [7:0]                    c,
   output logic signed [SUM_WIDTH-1:0]   sum,
   input  logic [10*ARG_WIDTH-1:0]       am_in,
   input  logic                          am_start,
   output logic [3:0]                    am_idx,
   output logic                          am_done
);

   function automatic int tree_levels(input int n);
      int lvl;
      int span;
      lvl  = 0;
      span = 1;
      while (span < n) begin
         span = span * 3;
         lvl  = lvl + 1;
      end
      return lvl;
   endfunction

   function automatic int level_count(input int n, input int lvl);
      int cnt;
      cnt = n;
      for (int i = 0; i < lvl; i++) cnt = (cnt + 2) / 3;
      return cnt;
   endfunction

   function automatic logic signed [17:0] lane_product(input logic [7:0] x,
                                                       input logic [7:0] w,
                                                       input logic [7:0] off);
      logic signed [8:0] diff;
      diff = 9'($signed(x)) - 9'($signed(off));
      return 18'(diff) * 18'($signed(w));
   endfunction

   localparam int LEVELS = tree_levels(N);
   localparam int DEPTH  = (LEVELS > 0) ? LEVELS : 1;

   logic [N*8-1:0] a_reg;
   logic [N*8-1:0] b_reg;
   logic [7:0]     c_reg;
   logic           en_reg;
   logic           acc_mode_reg;

   logic signed [MAC_WIDTH-1:0] acc_reg  [N];
   logic signed [SUM_WIDTH-1:0] leaf     [N];
   logic signed [SUM_WIDTH-1:0] tree_reg [DEPTH][N];

   always_ff @(posedge clk) begin
      if (reset) begin
         a_reg        <= '0;
         b_reg        <= '0;
         c_reg        <= '0;
         en_reg       <= 1'b0;
         acc_mode_reg <= 1'b0;
      end else begin
         a_reg        <= a;
         b_reg        <= b;
         c_reg        <= c;
         en_reg       <= en;
         acc_mode_reg <= acc;
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic signed [17:0] prod;
      assign prod = lane_product(a_reg[8*gi +: 8], b_reg[8*gi +: 8], c_reg);

      always_ff @(posedge clk) begin
         if (reset)
            acc_reg[gi] <= '0;
         else if (en_reg)
            acc_reg[gi] <= acc_mode_reg ? acc_reg[gi] + MAC_WIDTH'(prod) : MAC_WIDTH'(prod);
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) leaf[i] = SUM_WIDTH'(acc_reg[i]);
   end

   // Each level folds groups of three; missing group members contribute zero.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_level
      localparam int IN_CNT  = level_count(N, gi);
      localparam int OUT_CNT = level_count(N, gi + 1);

      logic signed [SUM_WIDTH-1:0] lvl_in [N];
      logic signed [SUM_WIDTH-1:0] grp    [N];

      if (gi == 0) begin : g_src
         always_comb begin
            for (int j = 0; j < N; j++) lvl_in[j] = leaf[j];
         end
      end else begin : g_src
         always_comb begin
            for (int j = 0; j < N; j++) lvl_in[j] = tree_reg[gi-1][j];
         end
      end

      always_comb begin
         for (int j = 0; j < N; j++) begin
            grp[j] = '0;
            for (int k = 0; k < 3; k++) begin
               if (3 * j + k < IN_CNT) grp[j] = grp[j] + lvl_in[3*j+k];
            end
         end
      end

      always_ff @(posedge clk) begin
         for (int j = 0; j < N; j++) begin
            if (reset || j >= OUT_CNT)
               tree_reg[gi][j] <= '0;
            else
               tree_reg[gi][j] <= grp[j];
         end
      end
   end

   if (LEVELS == 0) begin : g_sum_direct
      assign sum = leaf[0];
   end else begin : g_sum_tree
      assign sum = tree_reg[LEVELS-1][0];
   end

   typedef enum logic [1:0] {AM_IDLE, AM_SCAN, AM_DONE} am_state_t;

   am_state_t                   am_state_reg;
   logic signed [ARG_WIDTH-1:0] elem_reg [10];
   logic signed [ARG_WIDTH-1:0] best_reg;
   logic [3:0]                  best_idx_reg;
   logic [3:0]                  ptr_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         am_state_reg <= AM_IDLE;
         for (int k = 0; k < 10; k++) elem_reg[k] <= '0;
         best_reg     <= '0;
         best_idx_reg <= '0;
         ptr_reg      <= '0;
         am_idx       <= '0;
         am_done      <= 1'b0;
      end else begin
         case (am_state_reg)
            AM_IDLE: begin
               if (am_start) begin
                  for (int k = 0; k < 10; k++) elem_reg[k] <= am_in[ARG_WIDTH*k +: ARG_WIDTH];
                  best_reg     <= am_in[ARG_WIDTH-1:0];
                  best_idx_reg <= 4'd0;
                  ptr_reg      <= 4'd1;
                  am_state_reg <= AM_SCAN;
               end
            end
            AM_SCAN: begin
               // Strictly greater only, so ties keep the lowest index.
               if (elem_reg[ptr_reg] > best_reg) begin
                  best_reg     <= elem_reg[ptr_reg];
                  best_idx_reg <= ptr_reg;
               end
               ptr_reg <= ptr_reg + 4'd1;
               if (ptr_reg == 4'd9) begin
                  am_idx       <= (elem_reg[ptr_reg] > best_reg) ? ptr_reg : best_idx_reg;
                  am_done      <= 1'b1;
                  am_state_reg <= AM_DONE;
               end
            end
            AM_DONE: ;
            default: am_state_reg <= AM_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_sum_argmax.sv
// Randomised and directed checks of mac_sum_argmax against an arithmetic
// model of the lane accumulators, the tree latency and the argmax rule.
module tb_mac_sum_argmax;
   localparam int N   = 27;
   localparam int MW  = 24;
   localparam int SW  = 24;
   localparam int AW  = 8;
   localparam int LAT = 4;

   logic                   clk;
   logic                   reset;
   logic                   en;
   logic                   acc;
   logic [N*8-1:0]         a;
   logic [N*8-1:0]         b;
   logic [7:0]             c;
   logic signed [SW-1:0]   sum;
   logic [10*AW-1:0]       am_in;
   logic                   am_start;
   logic [3:0]             am_idx;
   logic                   am_done;

   mac_sum_argmax #(.N(N), .MAC_WIDTH(MW), .SUM_WIDTH(SW), .ARG_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .en(en), .acc(acc), .a(a), .b(b), .c(c),
      .sum(sum), .am_in(am_in), .am_start(am_start), .am_idx(am_idx), .am_done(am_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no end of test, expected completion");
      $fatal(1, "timeout");
   end

   int     n_assert;
   int     n_fail;
   int     cyc;
   longint lane_acc [N];
   longint hist [4096];
   int     scan_vals [10];

   function automatic longint wrap(input longint v, input int w);
      longint r;
      r = v & ((longint'(1) << w) - 1);
      if (r >= (longint'(1) << (w - 1))) r = r - (longint'(1) << w);
      return r;
   endfunction

   function automatic longint byte_s(input logic [7:0] x);
      return longint'($signed(x));
   endfunction

   function automatic int ref_argmax();
      int best;
      best = 0;
      for (int k = 1; k < 10; k++) if (scan_vals[k] > scan_vals[best]) best = k;
      return best;
   endfunction

   task automatic check(input string tag, input logic signed [63:0] obs, input longint expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // One clock: advance the model with the inputs present at this edge, then
   // compare sum with the model value from LAT edges earlier.
   task automatic step();
      longint p;
      longint tot;
      @(posedge clk);
      cyc++;
      if (reset) begin
         for (int i = 0; i < N; i++) lane_acc[i] = 0;
         for (int j = cyc - LAT; j <= cyc; j++) if (j >= 0) hist[j] = 0;
      end else begin
         if (en) begin
            for (int i = 0; i < N; i++) begin
               p = (byte_s(a[8*i +: 8]) - byte_s(c)) * byte_s(b[8*i +: 8]);
               lane_acc[i] = wrap(acc ? lane_acc[i] + p : p, MW);
            end
         end
         tot = 0;
         for (int i = 0; i < N; i++) tot += lane_acc[i];
         hist[cyc] = wrap(tot, SW);
      end
      #1;
      check("sum_pipe", $signed(sum), (cyc >= LAT) ? hist[cyc-LAT] : 0);
   endtask

   task automatic set_all(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] cv,
                          input logic e, input logic ac);
      for (int i = 0; i < N; i++) begin
         a[8*i +: 8] = av;
         b[8*i +: 8] = bv;
      end
      c   = cv;
      en  = e;
      acc = ac;
   endtask

   task automatic randomize_operands();
      for (int i = 0; i < N; i++) begin
         a[8*i +: 8] = 8'($urandom);
         b[8*i +: 8] = 8'($urandom);
      end
      c = 8'($urandom);
   endtask

   task automatic reset_cycle();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic scan_check();
      int exp_idx;
      for (int k = 0; k < 10; k++) am_in[AW*k +: AW] = AW'(scan_vals[k]);
      exp_idx  = ref_argmax();
      am_start = 1'b1;
      step();
      am_start = 1'b0;
      for (int t = 1; t <= 9; t++) begin
         if (t == 3) begin
            am_start = 1'b1;
            for (int k = 0; k < 10; k++) am_in[AW*k +: AW] = AW'($urandom);
         end
         if (t == 4) am_start = 1'b0;
         step();
         if (t < 9) begin
            check("am_busy_done", am_done, 0);
            check("am_busy_idx", am_idx, 0);
         end else begin
            check("am_done", am_done, 1);
            check("am_idx", am_idx, exp_idx);
         end
      end
      am_start = 1'b1;
      step();
      am_start = 1'b0;
      check("am_sticky_done", am_done, 1);
      check("am_sticky_idx", am_idx, exp_idx);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      cyc      = -1;
      for (int i = 0; i < N; i++) lane_acc[i] = 0;
      reset    = 1'b1;
      am_in    = '0;
      am_start = 1'b0;
      set_all(8'd0, 8'd0, 8'd0, 1'b0, 1'b0);

      step();
      step();
      check("rst_sum", $signed(sum), 0);
      check("rst_am_done", am_done, 0);
      check("rst_am_idx", am_idx, 0);
      reset = 1'b0;

      // Single load: (10-3)*2 = 14 per lane.
      set_all(8'd10, 8'd2, 8'd3, 1'b1, 1'b0);
      step();
      en = 1'b0;
      for (int t = 0; t < LAT; t++) begin
         randomize_operands();
         step();
      end
      check("load_sum", $signed(sum), 378);
      step();
      step();
      check("load_hold", $signed(sum), 378);

      // Accumulate three times 5*1.
      set_all(8'd5, 8'd1, 8'd0, 1'b1, 1'b0);
      step();
      acc = 1'b1;
      step();
      step();
      en = 1'b0;
      step();
      step();
      check("accum_1", $signed(sum), 135);
      step();
      check("accum_2", $signed(sum), 270);
      step();
      check("accum_3", $signed(sum), 405);

      // Extremes: (-128-127)*(-128) = 32640 per lane.
      set_all(8'h80, 8'h80, 8'h7F, 1'b1, 1'b0);
      step();
      en = 1'b0;
      for (int t = 0; t < LAT; t++) step();
      check("extreme_sum", $signed(sum), 881280);
      set_all(8'h80, 8'h80, 8'h7F, 1'b1, 1'b0);
      b[8*5 +: 8] = 8'h7F;
      step();
      en = 1'b0;
      for (int t = 0; t < LAT; t++) step();
      check("one_lane_sum", $signed(sum), 26 * 32640 - 32385);

      // Hold with en low and churning operands.
      for (int t = 0; t < 5; t++) begin
         randomize_operands();
         acc = 1'($urandom);
         step();
         check("hold_sum", $signed(sum), 26 * 32640 - 32385);
      end

      // Reset beats en in the same cycle.
      set_all(8'd10, 8'd2, 8'd3, 1'b1, 1'b1);
      reset_cycle();
      en = 1'b0;
      for (int t = 0; t < 5; t++) begin
         step();
         check("rst_flush", $signed(sum), 0);
      end

      // Random operand stream; every edge is checked by step().
      for (int t = 0; t < 80; t++) begin
         randomize_operands();
         en  = ($urandom_range(0, 3) != 0);
         acc = 1'($urandom);
         step();
      end
      en = 1'b0;
      for (int t = 0; t < LAT + 1; t++) step();

      // Argmax, directed vector with a tie at the maximum.
      reset_cycle();
      scan_vals = '{3, -5, 7, 7, 0, -128, 1, 2, 6, -1};
      scan_check();

      // Reset at S+4 aborts the scan.
      reset_cycle();
      for (int k = 0; k < 10; k++) am_in[AW*k +: AW] = AW'(8'h7F - k);
      am_start = 1'b1;
      step();
      am_start = 1'b0;
      for (int t = 0; t < 3; t++) step();
      reset_cycle();
      check("abort_done", am_done, 0);
      check("abort_idx", am_idx, 0);
      for (int t = 0; t < 10; t++) step();
      check("abort_stays_idle", am_done, 0);

      for (int k = 0; k < 10; k++) scan_vals[k] = -128;
      scan_check();

      // Random scans; a narrow range forces ties now and then.
      for (int r = 0; r < 6; r++) begin
         reset_cycle();
         for (int k = 0; k < 10; k++)
            scan_vals[k] = (r % 2 == 0) ? $urandom_range(0, 255) - 128 : $urandom_range(0, 6) - 3;
         scan_check();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/mac_sum_argmax.md
# mac_sum_argmax

Arithmetic core of the network processor. It holds N parallel multiply-accumulate lanes with an input offset pre-subtractor, and a pipelined ternary adder tree that reduces all lane accumulators to one neuron sum. It also contains a sequential argmax unit that returns the index of the largest of 10 signed bytes once inference finishes. The instruction sequencer drives it, and its sum feeds the requantization pipeline.

## Interface
Parameters:
- N, 27, number of MAC lanes (1..81).
- MAC_WIDTH, 24, signed width of each lane accumulator.
- SUM_WIDTH, 24, signed width of the tree output.
- ARG_WIDTH, 8, signed width of each argmax element.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears every register listed below.
- en  in  1  MAC enable for this cycle's operands.
- acc  in  1  1 = add the product to the accumulator; 0 = load the product.
- a  in  N*8  signed data byte per lane; lane i = bits [8i+7:8i].
- b  in  N*8  signed weight byte per lane, same packing.
- c  in  8  signed offset shared by all lanes.
- sum  out  SUM_WIDTH  signed sum of all lane accumulators.
- am_in  in  10*ARG_WIDTH  signed argmax elements; element k = bits [ARG_WIDTH*k+ARG_WIDTH-1 : ARG_WIDTH*k].
- am_start  in  1  request an argmax scan.
- am_idx  out  4  index 0..9 of the maximum element.
- am_done  out  1  result valid; sticky.

## Operation
MAC lane i has two register stages.
- Stage 1 (input regs): on every edge, register a_i, b_i, c, en and acc, with no condition.
- Stage 2 (accumulator): if en_r, compute p = (a_r − c_r) × b_r, where the difference is a 9-bit signed value and the product is 18-bit signed.
  - acc_r = 1: acc_i ← acc_i + sext(p).
  - acc_r = 0: acc_i ← sext(p).
  - Arithmetic wraps modulo 2^MAC_WIDTH.
- If en_r = 0, acc_i holds its value.

Adder tree:
- Levels = ceil(log3 N); 3 levels for N = 27.
- Each level sums groups of 3 (the last group may be 1–2, zero-padded) and registers the result.
- Inputs are sign-extended to SUM_WIDTH, and all additions wrap modulo 2^SUM_WIDTH.
- sum is the last level's register.

Argmax, states IDLE, SCAN, DONE:
- In IDLE, am_start = 1 moves to SCAN and captures all 10 elements. It also sets best = elem0, best_idx = 0 and ptr = 1.
- SCAN: each cycle, compare captured elem[ptr] with best as signed values. Replace best and best_idx only on strictly greater, so ties keep the lowest index. Then ptr increments.
- After comparing ptr = 9, go to DONE: am_idx ← best_idx and am_done ← 1 at the same edge.
- DONE holds until reset. am_start is ignored in SCAN and DONE.
- am_in changes after capture do not affect the result.

Reset values:
- All MAC input regs, accumulators and tree regs are 0, so sum = 0.
- Argmax is IDLE with am_idx = 0 and am_done = 0.
- Reset has priority over en and am_start in the same cycle.
- Reset during SCAN aborts the scan and returns to IDLE.

## Timing
- Operands sampled at edge E0 update acc_i at E1. Their contribution appears on sum after E1 + levels, i.e. E4 for N = 27, so sum latency is 4 edges.
- Back-to-back en cycles are fully pipelined, one operand set per cycle.
- acc is paired with the operands sampled at the same edge.
- Argmax: am_start sampled at edge S. am_done and am_idx update at edge S+9 (9 compare cycles) and are visible in the cycle after that edge.
- am_idx outside DONE equals its reset/last value (0 after reset).

## Test plan
- Single load: all lanes a = 10, c = 3, b = 2, en = 1, acc = 0 for one cycle -> each acc_i = 14; sum = 378 exactly 4 edges after sampling, then holds.
- Accumulate: 1st cycle acc = 0 with a = 5, c = 0, b = 1; next two cycles acc = 1 with the same operands -> acc_i = 15; final sum = 405. Each intermediate sum (135, 270) appears in consecutive cycles.
- Extremes: a = −128, c = 127, b = −128 on all lanes -> p = 32640; sum = 881280. Then one lane with b = 127, acc = 0 -> that lane = −32385.
- Hold and enable: en = 0 with changing a/b/c for 5 cycles -> sum unchanged. Then reset -> sum = 0 after reset plus tree flush.
- Argmax: am_in = {3, −5, 7, 7, 0, −128, 1, 2, 6, −1}, pulse am_start -> am_idx = 2 and am_done = 1 at S+9. am_in changes during SCAN are ignored, and a second am_start is ignored.
- Reset mid-scan: reset at S+4 -> am_done = 0, am_idx = 0. A new scan of all −128 -> am_idx = 0.
